if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_defs_pkg.sv | 15 +
 rtl/if_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU-wide constants: boot PC, exception vector and the IF-to-ID payload.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_bus_t;

  localparam int unsigned FS_TO_DS_BUS_W = $bits(fs_to_ds_bus_t);

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, delay-slot/pending-branch handling,
// stall buffering of SRAM read data and fetch address-error detection.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adel,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_adel;
  logic [31:0] r_buf;
  logic        r_buf_valid;
  logic        r_bp_valid;
  logic [31:0] r_bp_target;

  logic        w_fs_allowin;
  logic [31:0] w_nextpc;
  logic        w_nextpc_aligned;

  // Redirect priority: flush, then a branch whose delay slot is already in IF.
  always_comb begin
    w_fs_allowin = !r_fs_valid | ds_allowin | flush;
    w_nextpc     = r_fs_pc + 32'd4;
    if (flush)
      w_nextpc = flush_pc;
    else if (r_bp_valid && r_fs_valid)
      w_nextpc = r_bp_target;
    else if (br_taken && r_fs_valid)
      w_nextpc = br_target;
    w_nextpc_aligned = (w_nextpc[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fs_valid <= 1'b0;
      r_fs_pc    <= RESET_PC - 32'd4;
      r_adel     <= 1'b0;
    end else if (w_fs_allowin) begin
      r_fs_valid <= 1'b1;
      r_fs_pc    <= w_nextpc;
      r_adel     <= !w_nextpc_aligned;
    end
  end

  // Hold the returned word across a stall since the SRAM output is not held.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf       <= 32'h0;
    end else if (w_fs_allowin) begin
      r_buf_valid <= 1'b0;
    end else if (r_fs_valid && !ds_allowin && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_buf       <= inst_sram_rdata;
    end
  end

  // A branch seen with no delay slot in IF, or while stalled, waits here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bp_valid  <= 1'b0;
      r_bp_target <= 32'h0;
    end else if (flush) begin
      r_bp_valid <= 1'b0;
    end else if (br_taken && (!r_fs_valid || !w_fs_allowin)) begin
      r_bp_valid  <= 1'b1;
      r_bp_target <= br_target;
    end else if (w_fs_allowin && r_bp_valid && r_fs_valid) begin
      r_bp_valid <= 1'b0;
    end
  end

  assign fs_to_ds_valid  = r_fs_valid & !flush;
  assign fs_pc           = r_fs_pc;
  assign fs_adel         = r_adel;
  assign fs_inst         = r_adel ? NOP_INST : (r_buf_valid ? r_buf : inst_sram_rdata);
  assign inst_sram_en    = resetn & w_fs_allowin & w_nextpc_aligned;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'h0;

endmodule
